// File: rtl/sbox_pkg.sv
// Shared constants for the S-DES S-box lookup engine: the S0 table,
// FSM state codes and lane bus width helpers.
package sbox_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   // S-DES S0 box, indexed by the raw 4-bit input value.
   function automatic logic [1:0] s0_entry(input logic [3:0] idx);
      logic [1:0] val;
      case (idx)
         4'd0:    val = 2'd1;
         4'd1:    val = 2'd3;
         4'd2:    val = 2'd0;
         4'd3:    val = 2'd2;
         4'd4:    val = 2'd3;
         4'd5:    val = 2'd1;
         4'd6:    val = 2'd2;
         4'd7:    val = 2'd0;
         4'd8:    val = 2'd0;
         4'd9:    val = 2'd3;
         4'd10:   val = 2'd2;
         4'd11:   val = 2'd1;
         4'd12:   val = 2'd1;
         4'd13:   val = 2'd3;
         4'd14:   val = 2'd3;
         default: val = 2'd2;
      endcase
      return val;
   endfunction

   function automatic int lane_bus_w(input int lanes, input int width);
      return lanes * width;
   endfunction

endpackage

// File: rtl/sbox_lane_read.sv
// One lane's read port into the flattened S-box table: index in, entry out.
module sbox_lane_read #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 2
) (
   input  logic [(2**IN_W)*OUT_W-1:0] table_flat,
   input  logic [IN_W-1:0]            idx,
   output logic [OUT_W-1:0]           entry
);

   localparam int DEPTH = 2 ** IN_W;

   always_comb begin
      entry = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx == IN_W'(i)) begin
            entry = table_flat[i*OUT_W +: OUT_W];
         end
      end
   end

endmodule

// File: rtl/sbox_lut_engine.sv
// Runtime-programmable S-box lookup engine: register-file table shared by
// LANES lookup lanes, one registered output stage, sequenced clear and write port.
module sbox_lut_engine
   import sbox_pkg::*;
#(
   parameter int IN_W         = 4,
   parameter int OUT_W        = 2,
   parameter int LANES        = 2,
   parameter int INIT_SDES_S0 = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   input  logic                   cfg_we,
   input  logic [IN_W-1:0]        cfg_addr,
   input  logic [OUT_W-1:0]       cfg_data,
   input  logic                   cfg_clr,
   output logic                   cfg_busy,
   output logic                   cfg_err
);

   localparam int DEPTH    = 2 ** IN_W;
   localparam int OUT_BUSW = lane_bus_w(LANES, OUT_W);

   logic [OUT_W-1:0]          table_reg [DEPTH];
   logic [DEPTH*OUT_W-1:0]    table_flat;
   logic [OUT_BUSW-1:0]       lookup;
   logic [0:0]                state_reg;
   logic [IN_W-1:0]           cnt_reg;
   logic                      out_valid_reg;
   logic [OUT_BUSW-1:0]       out_data_reg;
   logic                      cfg_err_reg;
   logic                      accept;
   logic                      in_idle;
   logic                      clr_done;

   assign in_idle  = (state_reg == ST_IDLE);
   assign in_ready = in_idle && !cfg_we && !cfg_clr && (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;
   assign clr_done = (cnt_reg == {IN_W{1'b1}});

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign cfg_busy  = (state_reg == ST_CLEAR);
   assign cfg_err   = cfg_err_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
         assign table_flat[gi*OUT_W +: OUT_W] = table_reg[gi];
      end
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         sbox_lane_read #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
         ) u_lane (
            .table_flat (table_flat),
            .idx        (in_data[gi*IN_W +: IN_W]),
            .entry      (lookup[gi*OUT_W +: OUT_W])
         );
      end
   endgenerate

   // Table: reset restores init contents; clear sweeps one entry per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_reg[i] <= (INIT_SDES_S0 != 0) ? OUT_W'(s0_entry(4'(i))) : '0;
         end
      end else if (state_reg == ST_CLEAR) begin
         table_reg[cnt_reg] <= '0;
      end else if (cfg_we && !cfg_clr) begin
         table_reg[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cfg_clr) begin
                  state_reg <= ST_CLEAR;
                  cnt_reg   <= '0;
               end
            end
            default: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (clr_done) begin
                  state_reg <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Dropped config requests: write colliding with clear start, or anything during clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_err_reg <= 1'b0;
      end else if (in_idle ? (cfg_clr && cfg_we) : (cfg_clr || cfg_we)) begin
         cfg_err_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= lookup;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sbox_lut_engine.sv
// Randomized and directed checks of sbox_lut_engine against a table/queue model.
module tb_sbox_lut_engine;

   localparam int IN_W  = 4;
   localparam int OUT_W = 2;
   localparam int LANES = 2;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] out_data;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_addr = '0;
   logic [1:0] cfg_data = '0;
   logic       cfg_clr = 1'b0;
   logic       cfg_busy;
   logic       cfg_err;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [1:0] s0_ref [DEPTH] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0,
                                  2'd0, 2'd3, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2};
   logic [1:0] tbl_m [DEPTH];
   logic       ov_m;
   logic [3:0] od_m;
   int         busy_left;
   logic       err_m;

   sbox_lut_engine #(
      .IN_W         (IN_W),
      .OUT_W        (OUT_W),
      .LANES        (LANES),
      .INIT_SDES_S0 (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_clr   (cfg_clr),
      .cfg_busy  (cfg_busy),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) tbl_m[i] = s0_ref[i];
      ov_m = 1'b0;
      od_m = '0;
      busy_left = 0;
      err_m = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(ov_m));
      check({tag, ".out_data"},  32'(out_data),  32'(od_m));
      check({tag, ".cfg_busy"},  32'(cfg_busy),  32'(busy_left > 0));
      check({tag, ".cfg_err"},   32'(cfg_err),   32'(err_m));
   endtask

   // One clock cycle: drive, check in_ready, advance model, check registered outputs.
   task automatic step(input string tag, input logic iv, input logic [7:0] idata,
                       input logic ordy, input logic we, input logic [3:0] addr,
                       input logic [1:0] data, input logic clr);
      logic exp_ready;
      in_valid  = iv;
      in_data   = idata;
      out_ready = ordy;
      cfg_we    = we;
      cfg_addr  = addr;
      cfg_data  = data;
      cfg_clr   = clr;
      #1;
      exp_ready = (busy_left == 0) && !we && !clr && (!ov_m || ordy);
      check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
      if (iv && exp_ready) begin
         od_m = {tbl_m[idata[7:4]], tbl_m[idata[3:0]]};
         ov_m = 1'b1;
         $display("beat %s: lanes {0x%0h,0x%0h} -> {%0d,%0d}", tag, idata[3:0], idata[7:4],
                  od_m[1:0], od_m[3:2]);
      end else if (ordy) begin
         ov_m = 1'b0;
      end
      if (busy_left > 0) begin
         if (we || clr) err_m = 1'b1;
         busy_left--;
         if (busy_left == 0) begin
            for (int i = 0; i < DEPTH; i++) tbl_m[i] = '0;
         end
      end else if (clr) begin
         if (we) err_m = 1'b1;
         busy_left = DEPTH;
      end else if (we) begin
         tbl_m[addr] = data;
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      cfg_we = 1'b0;
      cfg_clr = 1'b0;
      out_ready = 1'b1;
      model_reset();
      #2;
      check_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Lanes {0x0,0xF} -> {1,2}
      step("first", 1'b1, 8'hF0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      check("first.lanes", 32'(out_data), 32'({2'd2, 2'd1}));

      for (int i = 0; i < DEPTH; i++) begin
         step("stream", 1'b1, {4'(15 - i), 4'(i)}, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      end

      // Backpressure: hold a result three cycles while a new beat waits
      step("bp_beat", 1'b1, 8'h12, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step("bp_hold", 1'b1, 8'h34, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      end
      step("bp_release", 1'b1, 8'h34, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      step("bp_drain", 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);

      // Table write then lookup
      step("wr5", 1'b1, 8'h55, 1'b1, 1'b1, 4'd5, 2'd0, 1'b0);
      step("rd5", 1'b1, 8'h55, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);

      // Clear with a dropped write in the middle
      step("clr_start", 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         step("clr_run", 1'b1, 8'($urandom), 1'b1, (i == 3), 4'd2, 2'd3, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         step("post_clr", 1'b1, 8'($urandom), 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      end

      // Reset mid-clear with a held result
      do_reset();
      step("rc_beat", 1'b1, 8'h77, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      step("rc_clr", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step("rc_run", 1'b0, 8'h00, 1'b0, (i == 2), 4'd0, 2'd0, 1'b0);
      end
      check("rc.pre_valid", 32'(out_valid), 32'd1);
      do_reset();
      step("rc_lookup1", 1'b1, 8'h11, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      check("rc.lookup1", 32'(out_data), 32'({2'd3, 2'd3}));

      // Random traffic with occasional configuration
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
              1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
              4'($urandom), 2'($urandom), ($urandom_range(0, 99) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
